// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between the CPU and a
// DMA/boot-loader engine. Round-robin between the two requesters, a CPU lock
// for read-modify-write sequences, and DMA-only ownership while boot is high.
// Each access takes three cycles: arbitration in IDLE, one grant cycle with
// mem_en high, and one ack cycle that returns the RAM read data.

module mem_arbiter #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 boot,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic                 cpu_lock,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic                 cpu_ack,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    input  logic                 dma_req,
    input  logic                 dma_we,
    input  logic [ADDR_SIZE-1:0] dma_addr,
    input  logic [WORD_SIZE-1:0] dma_wdata,
    output logic                 dma_ack,
    output logic [WORD_SIZE-1:0] dma_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 owner,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GNT_CPU = 3'd1,
        ACK_CPU = 3'd2,
        GNT_DMA = 3'd3,
        ACK_DMA = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   locked;
    logic                   locked_next;
    logic                   owner_next;
    logic                   busy_next;
    logic                   mem_en_next;
    logic                   mem_we_next;
    logic [ADDR_SIZE-1:0]   mem_addr_next;
    logic [WORD_SIZE-1:0]   mem_wdata_next;
    logic                   cpu_ack_next;
    logic                   dma_ack_next;
    logic                   cpu_eligible;
    logic                   dma_eligible;

    // Boot shuts the CPU out and also overrides any CPU lock held against DMA.
    assign cpu_eligible = cpu_req & ~boot;
    assign dma_eligible = dma_req & ~(locked & ~boot);

    // Next-state, grant capture, lock tracking and registered-output values.
    always_comb begin
        state_next     = state;
        locked_next    = locked;
        owner_next     = owner;
        mem_en_next    = 1'b0;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        cpu_ack_next   = 1'b0;
        dma_ack_next   = 1'b0;

        case (state)
            IDLE: begin
                if (!cpu_lock) begin
                    locked_next = 1'b0;
                end
                // On a tie the requester that is not the last owner wins.
                if (cpu_eligible && (!dma_eligible || owner)) begin
                    state_next     = GNT_CPU;
                    owner_next     = 1'b0;
                    mem_en_next    = 1'b1;
                    mem_we_next    = cpu_we;
                    mem_addr_next  = cpu_addr;
                    mem_wdata_next = cpu_wdata;
                end else if (dma_eligible) begin
                    state_next     = GNT_DMA;
                    owner_next     = 1'b1;
                    mem_en_next    = 1'b1;
                    mem_we_next    = dma_we;
                    mem_addr_next  = dma_addr;
                    mem_wdata_next = dma_wdata;
                end
            end
            GNT_CPU: begin
                state_next   = ACK_CPU;
                cpu_ack_next = 1'b1;
            end
            ACK_CPU: begin
                state_next  = IDLE;
                locked_next = cpu_lock;
            end
            GNT_DMA: begin
                state_next   = ACK_DMA;
                dma_ack_next = 1'b1;
            end
            ACK_DMA: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            locked    <= 1'b0;
            owner     <= 1'b1;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
        end else begin
            state     <= state_next;
            locked    <= locked_next;
            owner     <= owner_next;
            busy      <= busy_next;
            mem_en    <= mem_en_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            cpu_ack   <= cpu_ack_next;
            dma_ack   <= dma_ack_next;
        end
    end

    // RAM data arrives in the ack cycle, so it is steered straight through; writes return zero.
    assign cpu_rdata = (state == ACK_CPU && !mem_we) ? mem_rdata : WORD_SIZE'(0);
    assign dma_rdata = (state == ACK_DMA && !mem_we) ? mem_rdata : WORD_SIZE'(0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a synchronous RAM, a transaction-level reference
// model checked every cycle, and directed scenarios with literal expectations.

module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        boot;
    logic        cpu_req, cpu_we, cpu_lock;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [7:0]  dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_ack;
    logic [15:0] dma_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        owner, busy;

    int n_vec = 0;
    int n_bad = 0;

    mem_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(8)) dut (
        .clk(clk), .rst(rst), .boot(boot),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM seen by the arbiter.
    logic [15:0] ram [0:255];
    logic [15:0] ram_q = 16'h0000;
    assign mem_rdata = ram_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction with an age in cycles since its grant.
    logic [15:0] ref_mem [0:255];
    bit          m_active = 1'b0;
    int          m_age = 0;
    bit          m_who = 1'b0;
    bit          m_owner = 1'b1;
    bit          m_locked = 1'b0;
    logic        m_we = 1'b0;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_wdata = 16'h0000;
    logic [15:0] m_exp_rd = 16'h0000;

    always @(posedge clk or posedge rst) begin
        bit e_cpu, e_dma;
        if (rst) begin
            m_active = 1'b0; m_age = 0; m_owner = 1'b1; m_locked = 1'b0;
            m_we = 1'b0; m_addr = 8'h00; m_wdata = 16'h0000; m_exp_rd = 16'h0000;
        end else if (m_active) begin
            m_age++;
            if (m_age == 2) begin
                if (m_we) ref_mem[m_addr] = m_wdata;
            end else if (m_age >= 3) begin
                if (m_who == 1'b0) m_locked = cpu_lock;
                m_active = 1'b0;
            end
        end else begin
            e_cpu = cpu_req && !boot;
            e_dma = dma_req && !(m_locked && !boot);
            if (e_cpu || e_dma) begin
                m_who    = (e_cpu && e_dma) ? !m_owner : e_dma;
                m_we     = m_who ? dma_we    : cpu_we;
                m_addr   = m_who ? dma_addr  : cpu_addr;
                m_wdata  = m_who ? dma_wdata : cpu_wdata;
                m_exp_rd = ref_mem[m_addr];
                m_owner  = m_who;
                m_active = 1'b1;
                m_age    = 1;
            end
            if (!cpu_lock) m_locked = 1'b0;
        end
    end

    // Per-cycle comparison against the model, plus an ack log for order checks.
    int unsigned tcyc = 0;
    bit          ack_who [$];
    int unsigned ack_cyc [$];
    int          cpu_ack_in_boot = 0;

    always @(negedge clk) begin
        bit e_en, e_cack, e_dack;
        tcyc++;
        e_en   = m_active && m_age == 1;
        e_cack = m_active && m_age == 2 && m_who == 1'b0;
        e_dack = m_active && m_age == 2 && m_who == 1'b1;
        check("mem_en",    32'(mem_en),    32'(e_en));
        check("mem_we",    32'(mem_we),    32'(m_we));
        check("mem_addr",  32'(mem_addr),  32'(m_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        check("cpu_ack",   32'(cpu_ack),   32'(e_cack));
        check("dma_ack",   32'(dma_ack),   32'(e_dack));
        check("cpu_rdata", 32'(cpu_rdata), (e_cack && !m_we) ? 32'(m_exp_rd) : 32'h0);
        check("dma_rdata", 32'(dma_rdata), (e_dack && !m_we) ? 32'(m_exp_rd) : 32'h0);
        check("owner",     32'(owner),     32'(m_owner));
        check("busy",      32'(busy),      32'(m_active));
        if (cpu_ack) begin ack_who.push_back(1'b0); ack_cyc.push_back(tcyc); end
        if (dma_ack) begin ack_who.push_back(1'b1); ack_cyc.push_back(tcyc); end
        if (cpu_ack && boot) cpu_ack_in_boot++;
    end

    task automatic cpu_op(input logic we, input logic [7:0] a, input logic [15:0] d,
                          input logic lk, output logic [15:0] rd, output int lat);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_lock = lk; cpu_req = 1'b1;
        rd = 16'h0000;
        for (lat = 1; lat <= 60; lat++) begin
            @(negedge clk);
            if (cpu_ack) break;
        end
        if (lat > 60) check("cpu_ack_timeout", 32'(cpu_ack), 32'h1);
        else          rd = cpu_rdata;
        @(posedge clk); #1;
    endtask

    task automatic dma_op(input logic we, input logic [7:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
        dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
        rd = 16'h0000;
        for (lat = 1; lat <= 60; lat++) begin
            @(negedge clk);
            if (dma_ack) break;
        end
        if (lat > 60) check("dma_ack_timeout", 32'(dma_ack), 32'h1);
        else          rd = dma_rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] rd, rd2;
        int          lat, lat2;

        for (int i = 0; i < 256; i++) begin
            ram[i] = 16'h0000; ref_mem[i] = 16'h0000;
        end
        ram[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;
        ram[8'h20] = 16'h1234; ref_mem[8'h20] = 16'h1234;

        rst = 1'b1; boot = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_owner",  32'(owner),  32'h1);
        check("rst_busy",   32'(busy),   32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_addr",   32'(mem_addr), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single CPU read: ack on the third falling edge after the request is driven.
        cpu_op(1'b0, 8'h10, 16'h0000, 1'b0, rd, lat);
        cpu_req = 1'b0;
        check("t1_rdata", 32'(rd), 32'hBEEF);
        check("t1_latency", 32'(lat), 32'd3);

        // Reset in the middle of a DMA grant aborts it without an ack.
        @(posedge clk); #1;
        dma_we = 1'b1; dma_addr = 8'h40; dma_wdata = 16'h7777; dma_req = 1'b1;
        @(posedge clk); #3;
        check("t2_gnt_mem_en", 32'(mem_en), 32'h1);
        rst = 1'b1;
        #1;
        check("t2_rst_mem_en", 32'(mem_en), 32'h0);
        check("t2_rst_busy",   32'(busy),   32'h0);
        check("t2_rst_owner",  32'(owner),  32'h1);
        dma_req = 1'b0;
        #2 rst = 1'b0;
        ack_who.delete(); ack_cyc.delete();
        repeat (5) @(negedge clk);
        check("t2_no_ack", 32'(ack_who.size()), 32'h0);

        // Both requesters held after reset: strict alternation starting with the CPU.
        @(posedge clk); #1;
        ack_who.delete(); ack_cyc.delete();
        fork
            begin
                cpu_op(1'b0, 8'h10, 16'h0000, 1'b0, rd, lat);
                cpu_op(1'b1, 8'h11, 16'hC0DE, 1'b0, rd, lat);
                cpu_req = 1'b0;
            end
            begin
                dma_op(1'b1, 8'h12, 16'hD001, rd2, lat2);
                dma_op(1'b0, 8'h11, 16'h0000, rd2, lat2);
                dma_req = 1'b0;
            end
        join
        check("t3_nacks", 32'(ack_who.size()), 32'd4);
        if (ack_who.size() == 4) begin
            check("t3_ord0", 32'(ack_who[0]), 32'h0);
            check("t3_ord1", 32'(ack_who[1]), 32'h1);
            check("t3_ord2", 32'(ack_who[2]), 32'h0);
            check("t3_ord3", 32'(ack_who[3]), 32'h1);
            check("t3_gap",  32'(ack_cyc[3] - ack_cyc[0]), 32'd9);
        end
        check("t3_dma_rd", 32'(rd2), 32'hC0DE);

        // Boot: DMA writes 0,2,4,6 to 0..3 while the CPU waits, then the CPU reads 2.
        @(posedge clk); #1;
        ack_who.delete(); cpu_ack_in_boot = 0;
        boot = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) dma_op(1'b1, 8'(i), 16'(2 * i), rd2, lat2);
                dma_req = 1'b0;
                boot = 1'b0;
            end
            begin
                cpu_op(1'b0, 8'h02, 16'h0000, 1'b0, rd, lat);
                cpu_req = 1'b0;
            end
        join
        check("t4_cpu_in_boot", 32'(cpu_ack_in_boot), 32'h0);
        check("t4_nacks", 32'(ack_who.size()), 32'd5);
        if (ack_who.size() == 5) check("t4_last_cpu", 32'(ack_who[4]), 32'h0);
        check("t4_cpu_rd", 32'(rd), 32'h0004);

        // Locked read-modify-write: the CPU write slips in ahead of a waiting DMA.
        @(posedge clk); #1;
        ack_who.delete();
        fork
            begin
                cpu_op(1'b0, 8'h20, 16'h0000, 1'b1, rd, lat);
                cpu_op(1'b1, 8'h20, rd + 16'h0001, 1'b0, rd2, lat);
                cpu_req = 1'b0;
            end
            begin
                @(posedge clk); #1;
                dma_op(1'b0, 8'h20, 16'h0000, rd2, lat2);
                dma_req = 1'b0;
            end
        join
        check("t5_nacks", 32'(ack_who.size()), 32'd3);
        if (ack_who.size() == 3) begin
            check("t5_ord0", 32'(ack_who[0]), 32'h0);
            check("t5_ord1", 32'(ack_who[1]), 32'h0);
            check("t5_ord2", 32'(ack_who[2]), 32'h1);
        end
        check("t5_rmw_rd", 32'(rd), 32'h1234);
        check("t5_dma_rd", 32'(rd2), 32'h1235);

        // Write then read across requesters at the top of the address range.
        @(posedge clk); #1;
        dma_op(1'b1, 8'hFE, 16'h5A5A, rd2, lat2);
        dma_req = 1'b0;
        check("t6_wr_rdata", 32'(rd2), 32'h0);
        cpu_op(1'b0, 8'hFE, 16'h0000, 1'b0, rd, lat);
        cpu_req = 1'b0;
        check("t6_rd_rdata", 32'(rd), 32'h5A5A);
        check("t6_latency", 32'(lat), 32'd3);

        repeat (3) @(posedge clk);
        #1;
        check("end_busy", 32'(busy), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one synchronous single-port memory between two requesters: the cpu core's data/instruction port and a DMA/boot-loader engine.
- Round-robin arbitration with a CPU lock for read-modify-write sequences.
- During boot the DMA engine has exclusive ownership.
- Sits between the requesters and the RAM, replacing the direct shared-bus hookup.

Parameters:
WORD_SIZE, 16, data width of memory and requester data ports
ADDR_SIZE, 8, address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
boot  input  1  boot phase; while high only DMA is granted
cpu_req  input  1  CPU access request, held until cpu_ack
cpu_we  input  1  CPU write (1) / read (0)
cpu_lock  input  1  CPU holds ownership after current access
cpu_addr  input  ADDR_SIZE  CPU address
cpu_wdata  input  WORD_SIZE  CPU write data
cpu_ack  output  1  one-cycle completion pulse to CPU
cpu_rdata  output  WORD_SIZE  CPU read data, valid with cpu_ack
dma_req  input  1  DMA access request, held until dma_ack
dma_we  input  1  DMA write/read
dma_addr  input  ADDR_SIZE  DMA address
dma_wdata  input  WORD_SIZE  DMA write data
dma_ack  output  1  one-cycle completion pulse to DMA
dma_rdata  output  WORD_SIZE  DMA read data, valid with dma_ack
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  ADDR_SIZE  memory address
mem_wdata  output  WORD_SIZE  memory write data
mem_rdata  input  WORD_SIZE  memory read data, valid one cycle after mem_en
owner  output  1  0=CPU, 1=DMA; last/current grantee
busy  output  1  high when not IDLE

Behaviour:
- Reset (async): state=IDLE, owner=1 (so CPU wins the first tie), locked=0. All outputs are 0 (acks, mem_en, mem_we, mem_addr, mem_wdata, rdata).
- States: IDLE, GNT_CPU, ACK_CPU, GNT_DMA, ACK_DMA.
- IDLE: arbitrate on the registered clock edge.
  - Eligible CPU = cpu_req & !boot.
  - Eligible DMA = dma_req & !(locked & !boot).
  - Both eligible: grant the requester that is not owner (round-robin). One eligible: grant it. None: stay in IDLE.
- GNT_x: lasts one cycle.
  - mem_en=1; mem_we/mem_addr/mem_wdata are registered copies of x's inputs, captured on entry.
  - owner=x. Next state ACK_x.
- ACK_x: lasts one cycle.
  - x_ack=1; x_rdata=mem_rdata for reads, 0 for writes; mem_en=0.
  - Next state IDLE.
  - On CPU accesses only, locked <= cpu_lock sampled in ACK_CPU.
- Latency: request seen in IDLE at edge N -> mem_en during cycle N+1 -> ack during cycle N+2. Throughput is 1 access per 3 cycles per requester.
- Requester rule: keep req and address/data stable until ack; drop or replace them in the cycle after ack. The arbiter never re-arbitrates in ACK_x, so a held req is not double-granted.
- Lock:
  - While locked=1 and boot=0, DMA is ineligible.
  - locked clears when cpu_lock=0 is sampled in IDLE, or when a CPU ACK samples cpu_lock=0.
  - boot=1 overrides the lock.
- Boot:
  - CPU requests wait while boot=1.
  - If boot rises during GNT_CPU/ACK_CPU, that CPU access completes normally; later CPU requests wait.
- An ack is never asserted for a requester whose req was low at grant time.
- Outputs other than the acks, rdata and mem_en hold their last values in IDLE. Only mem_en qualifies the memory.
- Reset mid-transaction: immediate return to IDLE. No ack is issued for the aborted access, and mem_en drops asynchronously.

Test Plan:
- Single CPU read: preload mem[0x10]=0xBEEF; cpu_req, addr 0x10 -> mem_en one cycle later; cpu_ack with cpu_rdata=0xBEEF two cycles after the request edge; dma_ack stays 0.
- Simultaneous requests after reset: cpu_req and dma_req both held continuously -> grant order CPU, DMA, CPU, DMA; acks 3 cycles apart; owner toggles.
- Boot exclusivity: boot=1, both requesting -> only DMA granted (DMA writes 0x0000..0x0006 complete); cpu_ack=0 until boot falls, then the CPU is served.
- Lock RMW: CPU read 0x20 with cpu_lock=1, dma_req asserted -> the next grant goes to CPU (write 0x20, lock=0) before any DMA grant.
- Async reset during GNT_DMA: rst pulses mid-cycle -> mem_en and busy drop immediately; no dma_ack; owner=1. The first post-reset tie goes to CPU.
- Write-then-read: DMA writes 0x5A5A to 0xFE, then CPU reads 0xFE -> cpu_rdata=0x5A5A; write acks return rdata=0.
